// File: rtl/a2d_sequencer.sv
// rtl/a2d_sequencer.sv - round-robin ADC128S conversion sequencer with battery priority
module a2d_sequencer #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        batt_req,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_cmplt,
    output logic [1:0]  cnv_ch
);

    typedef enum logic [1:0] {IDLE, CNV, GAP, RD} state_t;

    state_t     state, state_nxt;
    logic [1:0] slot, rr, sel_slot;
    logic       prio, batt_pend;
    logic       start, second_wrt, finish;

    function automatic logic [2:0] chan_of(input logic [1:0] s);
        case (s)
            2'd0:    chan_of = CH_LFT;
            2'd1:    chan_of = CH_RGHT;
            2'd2:    chan_of = CH_STEER;
            default: chan_of = CH_BATT;
        endcase
    endfunction

    // A coincident batt_req is honoured by the conversion it arrives with.
    assign sel_slot = (batt_pend | batt_req) ? 2'd3 : rr;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        second_wrt = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (nxt) begin
                start     = 1'b1;
                state_nxt = CNV;
            end
            CNV: if (done) state_nxt = GAP;
            GAP: begin
                second_wrt = 1'b1;
                state_nxt  = RD;
            end
            RD: if (done) begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            slot      <= 2'd0;
            prio      <= 1'b0;
            rr        <= 2'd0;
            batt_pend <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
            cnv_cmplt <= 1'b0;
            cnv_ch    <= 2'd0;
        end else begin
            state     <= state_nxt;
            wrt       <= start | second_wrt;
            cnv_cmplt <= finish;
            if (start) begin
                slot <= sel_slot;
                prio <= batt_pend | batt_req;
                cmd  <= {2'b00, chan_of(sel_slot), 11'h000};
            end
            if (start)
                batt_pend <= 1'b0;
            else if (batt_req)
                batt_pend <= 1'b1;
            // The first transaction only selects the mux; only the second read is kept.
            if (finish) begin
                case (slot)
                    2'd0:    lft_ld    <= rd_data[11:0];
                    2'd1:    rght_ld   <= rd_data[11:0];
                    2'd2:    steer_pot <= rd_data[11:0];
                    default: batt      <= rd_data[11:0];
                endcase
                cnv_ch <= slot;
                if (!prio) rr <= rr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb/tb_a2d_sequencer.sv - directed scoreboard bench for a2d_sequencer
module tb_a2d_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, nxt, batt_req, done;
    logic [15:0] rd_data;
    logic        wrt, busy, cnv_cmplt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic [1:0]  cnv_ch;

    typedef struct packed {
        logic [1:0]  slot;
        logic [11:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [11:0] exp_regs[4];
    int          total = 0;
    int          bad = 0;
    int          wrt_cnt = 0;
    logic        prev_wrt = 1'b0;

    a2d_sequencer dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .batt_req(batt_req),
        .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .busy(busy), .cnv_cmplt(cnv_cmplt), .cnv_ch(cnv_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic conv(input logic [15:0] exp_cmd, input logic [1:0] exp_slot,
                        input logic [11:0] data, input bit with_batt, input bit busy_nxt);
        int  w0;
        sb_t e;
        w0     = wrt_cnt;
        e.slot = exp_slot;
        e.data = data;
        sb.push_back(e);
        @(negedge clk); nxt = 1'b1; batt_req = with_batt;
        @(negedge clk); nxt = 1'b0; batt_req = 1'b0;
        chk("wrt_lat", {15'd0, wrt}, 16'd1);
        chk("cmd", cmd, exp_cmd);
        chk("busy_cnv", {15'd0, busy}, 16'd1);
        @(negedge clk); nxt = busy_nxt;
        @(negedge clk); nxt = 1'b0; done = 1'b1; rd_data = 16'h0ABC;
        @(negedge clk); done = 1'b0; rd_data = 16'h0000; nxt = busy_nxt;
        chk("wrt_gap", {15'd0, wrt}, 16'd0);
        @(negedge clk); nxt = 1'b0;
        chk("wrt_2nd", {15'd0, wrt}, 16'd1);
        chk("cmd_hold", cmd, exp_cmd);
        @(negedge clk); nxt = busy_nxt;
        chk("busy_rd", {15'd0, busy}, 16'd1);
        @(negedge clk); done = 1'b1; rd_data = {4'h0, data}; nxt = busy_nxt;
        @(negedge clk); done = 1'b0; nxt = 1'b0; rd_data = 16'h0000;
        chk("cmplt", {15'd0, cnv_cmplt}, 16'd1);
        chk("busy_end", {15'd0, busy}, 16'd0);
        @(negedge clk);
        chk("cmplt_pulse", {15'd0, cnv_cmplt}, 16'd0);
        @(negedge clk);
        chk("wrt_count", 16'(wrt_cnt - w0), 16'd2);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;
        rst_n = 1'b0; nxt = 1'b0; batt_req = 1'b0; done = 1'b0; rd_data = 16'h0000;

        // Output monitor: pops the scoreboard on every completion
        fork
            forever begin
                sb_t e;
                @(negedge clk);
                if (rst_n) begin
                    if (wrt) begin
                        wrt_cnt++;
                        chk("wrt_consec", {15'd0, prev_wrt}, 16'd0);
                    end
                    if (cnv_cmplt) begin
                        if (sb.size() == 0) begin
                            chk("stale_cmplt", {15'd0, cnv_cmplt}, 16'd0);
                        end else begin
                            e = sb.pop_front();
                            exp_regs[e.slot] = e.data;
                            chk("cnv_ch", {14'd0, cnv_ch}, {14'd0, e.slot});
                            chk("lft_ld", {4'd0, lft_ld}, {4'd0, exp_regs[0]});
                            chk("rght_ld", {4'd0, rght_ld}, {4'd0, exp_regs[1]});
                            chk("steer_pot", {4'd0, steer_pot}, {4'd0, exp_regs[2]});
                            chk("batt", {4'd0, batt}, {4'd0, exp_regs[3]});
                            chk("no_abc", {15'd0, (lft_ld == 12'hABC) || (rght_ld == 12'hABC) ||
                                (steer_pot == 12'hABC) || (batt == 12'hABC)}, 16'd0);
                        end
                    end
                end
                prev_wrt = wrt;
            end
        join_none

        @(negedge clk); @(negedge clk);
        chk("rst_wrt", {15'd0, wrt}, 16'd0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_cmplt", {15'd0, cnv_cmplt}, 16'd0);
        chk("rst_ch", {14'd0, cnv_ch}, 16'd0);
        chk("rst_regs", {4'd0, lft_ld | rght_ld | steer_pot | batt}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round robin through all four slots, then wrap
        conv(16'h0000, 2'd0, 12'h111, 1'b0, 1'b0);
        conv(16'h2000, 2'd1, 12'h222, 1'b0, 1'b0);
        conv(16'h2800, 2'd2, 12'h333, 1'b0, 1'b0);
        conv(16'h3000, 2'd3, 12'h8FF, 1'b0, 1'b0);
        conv(16'h0000, 2'd0, 12'h444, 1'b0, 1'b0);

        // Pending battery priority, then rr resumes at rght
        @(negedge clk); batt_req = 1'b1;
        @(negedge clk); batt_req = 1'b0;
        conv(16'h3000, 2'd3, 12'h9A1, 1'b0, 1'b0);
        conv(16'h2000, 2'd1, 12'h2B2, 1'b0, 1'b0);

        // batt_req coincident with nxt, rr stays on steer
        conv(16'h3000, 2'd3, 12'h7C3, 1'b1, 1'b0);
        conv(16'h2800, 2'd2, 12'h3D4, 1'b0, 1'b0);

        // nxt pulses in CNV, GAP, RD and with the final done
        conv(16'h3000, 2'd3, 12'h5E5, 1'b0, 1'b1);
        conv(16'h0000, 2'd0, 12'h555, 1'b0, 1'b0);

        // Reset mid-RD on a rght conversion
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        chk("abort_cmd", cmd, 16'h2000);
        @(negedge clk);
        @(negedge clk); done = 1'b1; rd_data = 16'h0ABC;
        @(negedge clk); done = 1'b0; rd_data = 16'h0000;
        @(negedge clk);
        chk("abort_wrt2", {15'd0, wrt}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wrt", {15'd0, wrt}, 16'd0);
        chk("arst_cmd", cmd, 16'h0000);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        chk("arst_ch", {14'd0, cnv_ch}, 16'd0);
        chk("arst_cmplt", {15'd0, cnv_cmplt}, 16'd0);
        chk("arst_regs", {4'd0, lft_ld | rght_ld | steer_pot | batt}, 16'd0);
        for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); done = 1'b1; rd_data = 16'h0777;
        @(negedge clk); done = 1'b0; rd_data = 16'h0000;
        chk("idle_done", {15'd0, cnv_cmplt | busy}, 16'd0);
        conv(16'h0000, 2'd0, 12'h666, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a2d_sequencer.md
Name: a2d_sequencer

Overview:
Sequences the shared SPI monarch that talks to the ADC128S A2D. It converts the four analog inputs (left load cell, right load cell, steer pot, battery) in round-robin order, one conversion per `nxt` request, and holds the latest 12-bit result for each. A pending battery-priority request pre-empts the round-robin order for one conversion. It sits between the Segway's conversion-rate timer and the SPI monarch. Results feed the rider-detect, steering and battery-low logic.

Parameters:
- CH_LFT, 3'd0, ADC channel number of the left load cell.
- CH_RGHT, 3'd4, ADC channel number of the right load cell.
- CH_STEER, 3'd5, ADC channel number of the steer pot.
- CH_BATT, 3'd6, ADC channel number of the battery.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- nxt  in  1  one-cycle pulse; start the next conversion.
- batt_req  in  1  one-cycle pulse; battery is converted at the next start.
- wrt  out  1  one-cycle pulse to the SPI monarch; starts a 16-bit transaction.
- cmd  out  16  SPI word: {2'b00, chnl[2:0], 11'h000}.
- done  in  1  one-cycle pulse from the SPI monarch; transaction complete.
- rd_data  in  16  SPI receive word; rd_data[11:0] is the result.
- lft_ld  out  12  latest left load-cell result.
- rght_ld  out  12  latest right load-cell result.
- steer_pot  out  12  latest steer-pot result.
- batt  out  12  latest battery result.
- busy  out  1  high while a conversion is in progress.
- cnv_cmplt  out  1  one-cycle pulse when a result register updates.
- cnv_ch  out  2  slot of the last completed conversion: 0 lft, 1 rght, 2 steer, 3 batt.

Behaviour:
- Reset values: all result registers 0; wrt 0; cmd 0; busy 0; cnv_cmplt 0; cnv_ch 0; round-robin pointer rr=0; batt_pend=0. Reset is asynchronous, and an assertion mid-conversion aborts it with no result update.
- Channel selection rules:
  - batt_pend is set by batt_req and cleared when a conversion starts with batt_pend=1.
  - If batt_req and the start coincide, the request is honoured by that same conversion.
  - At start, slot = 3 if (batt_pend | batt_req), else slot = rr. The slot is latched for the whole conversion.
  - rr advances (2-bit wrap, 3 -> 0) only when a round-robin (non-priority) conversion completes. A priority conversion leaves rr unchanged.
- State machine:
  - IDLE: busy=0. On nxt: latch slot, drive cmd with that slot's channel, pulse wrt, go to CNV.
  - CNV: busy=1; wait for done. This transaction only selects the channel; its rd_data is discarded. On done go to GAP.
  - GAP: exactly one cycle so the monarch deasserts SS_n. Then pulse wrt with the same cmd, go to RD.
  - RD: wait for done. On done, in the same edge: load rd_data[11:0] into the slot's register, pulse cnv_cmplt, set cnv_ch, go to IDLE.
- Handshake rules:
  - nxt while busy is ignored; it is not queued.
  - nxt arriving in the same cycle as the RD done is also ignored.
  - wrt is registered and never high for two consecutive cycles.
  - cmd is stable from the first wrt until return to IDLE.
- Latency: nxt -> first wrt is 1 cycle. First done -> second wrt is 2 cycles. Second done -> result visible is 1 cycle.
- A done received in IDLE is ignored.
- Registers not selected for a conversion hold their value.

Test Plan:
- Reset, then four nxt pulses with an SPI model returning 12'h111, 12'h222, 12'h333, 12'h8FF on the read transactions:
  - cmd sequence is 16'h0000, 16'h2000, 16'h2800, 16'h3000;
  - lft_ld=111, rght_ld=222, steer_pot=333, batt=8FF;
  - cnv_ch runs 0, 1, 2, 3.
- A fifth nxt: cmd wraps to 16'h0000 (rr wrapped to 0).
- batt_req after the first completion, then nxt:
  - battery is converted (cmd 16'h3000);
  - the next nxt converts rght (16'h2000), showing rr was not advanced by the priority conversion.
- nxt pulses during CNV, GAP and RD:
  - no extra wrt;
  - exactly two wrt per conversion;
  - busy stays high until cnv_cmplt.
- Cycle check on one conversion:
  - wrt one cycle after nxt;
  - second wrt two cycles after the first done;
  - cnv_cmplt and the updated register one cycle after the second done;
  - the first transaction's rd_data (set to 12'hABC) never appears on any output.
- rst_n asserted while in RD:
  - all outputs return to 0 asynchronously;
  - the subsequent nxt issues cmd 16'h0000 (rr=0);
  - no stale cnv_cmplt appears.
